// File: rtl/io_bus_ctl.sv
// io_bus_ctl: memory-mapped I/O bus controller.
// A CPU access is an I/O access when adr[23:6] is all ones and rd or wr is
// set. adr[5:2] selects one of N_DEV device slots. Slots at or above N_DEV
// read as zero and do not stall the CPU. A mapped access stalls the CPU and
// moves through IDLE -> ACC -> DONE. In ACC the selected device is enabled
// until it is ready, or until the access times out.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   adr, rd, wr       CPU byte address and read/write strobes
//   outbus / inbus    CPU write data / read data returned to the CPU
//   inbus0            memory read data, passed through on non-I/O cycles
//   stall             CPU stall request
//   dev_en            one-hot device select (ACC state only)
//   dev_wr            single-cycle device write strobe
//   dev_din           write data broadcast to all devices
//   dev_dout          packed device read data, 32 bits per slot
//   dev_rdy           per-device ready
//   err_clr           clears bus_err
//   bus_err, err_adr  sticky timeout flag and slot of the last timeout
module io_bus_ctl #(
  parameter int N_DEV    = 4,
  parameter int WAIT_CYC = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [23:0]         adr,
  input  logic                rd,
  input  logic                wr,
  input  logic [31:0]         outbus,
  input  logic [31:0]         inbus0,
  output logic [31:0]         inbus,
  output logic                stall,
  output logic [N_DEV-1:0]    dev_en,
  output logic                dev_wr,
  output logic [31:0]         dev_din,
  input  logic [32*N_DEV-1:0] dev_dout,
  input  logic [N_DEV-1:0]    dev_rdy,
  input  logic                err_clr,
  output logic                bus_err,
  output logic [3:0]          err_adr
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  k_q;
  logic        is_wr;
  logic [31:0] rdata;

  logic [3:0]  slot;
  logic        io_acc;
  logic        mapped;
  logic [31:0] sel_dout;
  logic        sel_rdy;
  logic        wait_met;
  logic        done_ok;
  logic        abort;
  logic        unused_adr;

  assign slot       = adr[5:2];
  assign io_acc     = (adr[23:6] == 18'h3FFFF) && (rd || wr);
  assign mapped     = io_acc && ({1'b0, slot} < 5'(N_DEV));
  assign dev_din    = outbus;
  assign unused_adr = ^adr[1:0];

  // Read data and ready of the latched slot.
  always_comb begin
    sel_dout = 32'h0;
    sel_rdy  = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (k_q == 4'(i)) begin
        sel_dout = dev_dout[i*32 +: 32];
        sel_rdy  = dev_rdy[i];
      end
    end
  end

  // With no wait requirement, the minimum-wait check is always satisfied.
  // This also avoids comparing cnt against zero.
  if (WAIT_CYC == 0) begin : g_nowait
    assign wait_met = 1'b1;
  end else begin : g_wait
    assign wait_met = (cnt >= 8'(WAIT_CYC));
  end

  assign done_ok = (state == ACC) && wait_met && sel_rdy;
  assign abort   = (state == ACC) && !done_ok && (cnt == 8'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'h0;
      k_q     <= 4'h0;
      is_wr   <= 1'b0;
      rdata   <= 32'h0;
      bus_err <= 1'b0;
      err_adr <= 4'h0;
    end else begin
      // When a new timeout and err_clr arrive together, the timeout wins.
      if (abort) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (mapped) begin
            cnt   <= 8'h0;
            k_q   <= slot;
            is_wr <= wr;
            state <= ACC;
          end
        end
        ACC: begin
          if (done_ok) begin
            if (!is_wr) begin
              rdata <= sel_dout;
            end
            state <= DONE;
          end else if (abort) begin
            rdata   <= 32'hFFFF_FFFF;
            err_adr <= k_q;
            state   <= DONE;
          end else if (cnt != 8'(TIMEOUT)) begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // stall must rise in the very cycle the access first appears. For that
  // reason the bus-side outputs are decoded from the current state and inputs.
  always_comb begin
    inbus  = inbus0;
    stall  = 1'b0;
    dev_en = '0;
    dev_wr = 1'b0;
    case (state)
      IDLE: begin
        if (io_acc) begin
          inbus = 32'h0;
          stall = mapped;
        end
      end
      ACC: begin
        inbus  = 32'h0;
        stall  = 1'b1;
        dev_wr = done_ok && is_wr;
        for (int i = 0; i < N_DEV; i++) begin
          dev_en[i] = (k_q == 4'(i));
        end
      end
      DONE: begin
        inbus = is_wr ? 32'h0 : rdata;
      end
      default: begin
        inbus = inbus0;
      end
    endcase
    if (rst) begin
      stall  = 1'b0;
      dev_en = '0;
      dev_wr = 1'b0;
    end
  end

endmodule

// File: tb/tb_io_bus_ctl.sv
// Directed testbench for io_bus_ctl.
// Instance a: N_DEV=4, WAIT_CYC=0, TIMEOUT=8.
// Instance b: N_DEV=4, WAIT_CYC=3, TIMEOUT=8. It has its own read strobe, so it
// stays idle except during its own test.
module tb_io_bus_ctl;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  adr;
  logic         rd, wr, rd_b, wr_b;
  logic [31:0]  outbus, inbus0;
  logic [127:0] dev_dout;
  logic [3:0]   dev_rdy;
  logic         err_clr;

  logic [31:0]  inbus, dev_din, inbus_b, dev_din_b;
  logic         stall, dev_wr, bus_err, stall_b, dev_wr_b, bus_err_b;
  logic [3:0]   dev_en, err_adr, dev_en_b, err_adr_b;

  int checks = 0;
  int errors = 0;
  int n;
  int wr_pulses;

  always #5 clk = ~clk;

  io_bus_ctl #(.N_DEV(4), .WAIT_CYC(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .outbus(outbus),
    .inbus0(inbus0), .inbus(inbus), .stall(stall), .dev_en(dev_en),
    .dev_wr(dev_wr), .dev_din(dev_din), .dev_dout(dev_dout),
    .dev_rdy(dev_rdy), .err_clr(err_clr), .bus_err(bus_err),
    .err_adr(err_adr)
  );

  io_bus_ctl #(.N_DEV(4), .WAIT_CYC(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd_b), .wr(wr_b), .outbus(outbus),
    .inbus0(inbus0), .inbus(inbus_b), .stall(stall_b), .dev_en(dev_en_b),
    .dev_wr(dev_wr_b), .dev_din(dev_din_b), .dev_dout(dev_dout),
    .dev_rdy(dev_rdy), .err_clr(err_clr), .bus_err(bus_err_b),
    .err_adr(err_adr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    adr      = 24'hFFFFC4;
    rd       = 1'b1;
    wr       = 1'b0;
    rd_b     = 1'b0;
    wr_b     = 1'b0;
    outbus   = 32'h0;
    inbus0   = 32'hCAFEBABE;
    dev_dout = {32'h55AA55AA, 32'hDEADBEEF, 32'h12345678, 32'h0BADF00D};
    dev_rdy  = 4'b1111;
    err_clr  = 1'b0;

    // Reset with an I/O access pending: outputs must stay quiet.
    nxt; smp;
    chk("rst_stall", stall, 0);
    chk("rst_dev_en", dev_en, 0);
    chk("rst_dev_wr", dev_wr, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_err_adr", err_adr, 0);

    // Read slot 1, no wait states.
    nxt; rst = 1'b0;
    smp;
    chk("rd1_idle_stall", stall, 1);
    chk("rd1_idle_en", dev_en, 0);
    nxt; smp;
    chk("rd1_acc_stall", stall, 1);
    chk("rd1_acc_en", dev_en, 4'b0010);
    chk("rd1_acc_wr", dev_wr, 0);
    nxt; smp;
    chk("rd1_done_stall", stall, 0);
    chk("rd1_done_inbus", inbus, 32'h12345678);
    chk("rd1_done_en", dev_en, 0);
    nxt; rd = 1'b0;
    smp;
    chk("idle_pass_inbus", inbus, 32'hCAFEBABE);

    // Non-I/O read, followed by a read of unmapped slot 9.
    nxt; adr = 24'h000100; rd = 1'b1;
    smp;
    chk("mem_stall", stall, 0);
    chk("mem_inbus", inbus, 32'hCAFEBABE);
    chk("mem_en", dev_en, 0);
    nxt; adr = 24'hFFFFE4;
    smp;
    chk("unmap_stall", stall, 0);
    chk("unmap_inbus", inbus, 32'h0);
    nxt; smp;
    chk("unmap_stall2", stall, 0);
    chk("unmap_en2", dev_en, 0);

    // Write slot 2. Ready rises in the sixth ACC cycle (cnt=5).
    nxt; rd = 1'b0; wr = 1'b1; adr = 24'hFFFFC8; outbus = 32'hA5A5A5A5;
    dev_rdy = 4'b1011;
    smp;
    chk("wr2_idle_stall", stall, 1);
    chk("wr2_din", dev_din, 32'hA5A5A5A5);
    wr_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      nxt; smp;
      if (dev_wr) wr_pulses++;
      chk("wr2_wait_stall", stall, 1);
      chk("wr2_wait_en", dev_en, 4'b0100);
    end
    nxt; dev_rdy = 4'b1111;
    smp;
    if (dev_wr) wr_pulses++;
    chk("wr2_pulse_en", dev_en, 4'b0100);
    chk("wr2_pulse_din", dev_din, 32'hA5A5A5A5);
    chk("wr2_pulse_wr", dev_wr, 1);
    nxt; smp;
    if (dev_wr) wr_pulses++;
    chk("wr2_done_stall", stall, 0);
    chk("wr2_done_inbus", inbus, 32'h0);
    chk("wr2_done_en", dev_en, 0);
    chk("wr2_pulse_count", wr_pulses, 1);

    // A read of slot 0 issued back to back in the cycle after DONE.
    nxt; wr = 1'b0; rd = 1'b1; adr = 24'hFFFFC0;
    smp;
    chk("b2b_idle_stall", stall, 1);
    nxt; smp;
    chk("b2b_acc_en", dev_en, 4'b0001);
    nxt; smp;
    chk("b2b_done_stall", stall, 0);
    chk("b2b_done_inbus", inbus, 32'h0BADF00D);

    // Read slot 3 that never becomes ready: expect TIMEOUT+2 = 10 stalls.
    nxt; adr = 24'hFFFFCC; dev_rdy = 4'b0111;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      smp;
      if (!stall) break;
      n++;
      nxt;
    end
    chk("to_stall_cycles", n, 10);
    chk("to_inbus", inbus, 32'hFFFFFFFF);
    chk("to_bus_err", bus_err, 1);
    chk("to_err_adr", err_adr, 3);
    nxt; rd = 1'b0; err_clr = 1'b1;
    nxt; err_clr = 1'b0;
    smp;
    chk("clr_bus_err", bus_err, 0);
    chk("clr_err_adr_kept", err_adr, 3);

    // Second timeout with err_clr held high: the timeout wins.
    nxt; rd = 1'b1; err_clr = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      smp;
      if (!stall) break;
      n++;
      nxt;
    end
    chk("to2_stall_cycles", n, 10);
    chk("to2_bus_err_wins", bus_err, 1);

    // Reset arrives in the third ACC cycle of a write to slot 1.
    nxt; err_clr = 1'b0; rd = 1'b0; wr = 1'b1; adr = 24'hFFFFC4;
    outbus = 32'h11112222; dev_rdy = 4'b1101;
    smp;
    chk("rw_idle_stall", stall, 1);
    nxt; nxt;
    nxt; rst = 1'b1; dev_rdy = 4'b1111;
    smp;
    chk("rw_rst_stall", stall, 0);
    chk("rw_rst_wr", dev_wr, 0);
    chk("rw_rst_en", dev_en, 0);
    nxt; rst = 1'b0; wr = 1'b0;
    smp;
    chk("rw_after_stall", stall, 0);
    chk("rw_after_inbus", inbus, 32'hCAFEBABE);
    chk("rw_after_bus_err", bus_err, 0);
    chk("rw_after_err_adr", err_adr, 0);
    nxt; rd = 1'b1; adr = 24'hFFFFC0;
    smp;
    chk("rw_new_idle_stall", stall, 1);
    chk("rw_new_idle_en", dev_en, 0);
    nxt; nxt; smp;
    chk("rw_new_done_inbus", inbus, 32'h0BADF00D);

    // WAIT_CYC=3 with ready held: the access completes at cnt=3, giving 5 stalls.
    nxt; rd = 1'b0; rd_b = 1'b1; adr = 24'hFFFFC0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      smp;
      if (!stall_b) break;
      n++;
      nxt;
    end
    chk("wait3_stall_cycles", n, 5);
    chk("wait3_inbus", inbus_b, 32'h0BADF00D);
    chk("wait3_a_idle", stall, 0);
    nxt; rd_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_ctl.md
IO_BUS_CTL -- requirements
Module: io_bus_ctl

Interface
REQ-001 SHALL have parameter N_DEV, default 4, number of I/O device slots (1..16).
REQ-002 SHALL have parameter WAIT_CYC, default 0, minimum ACC-state cycles before completion (0..15).
REQ-003 SHALL have parameter TIMEOUT, default 255, ACC-state cycle count at which an access aborts (must exceed WAIT_CYC, max 255).
REQ-004 SHALL have ports: clk  in  1  system clock, single clock domain for the whole block.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: adr  in  24  CPU byte address.
REQ-007 SHALL have ports: rd  in  1  CPU read strobe.
REQ-008 SHALL have ports: wr  in  1  CPU write strobe.
REQ-009 SHALL have ports: outbus  in  32  CPU write data.
REQ-010 SHALL have ports: inbus0  in  32  memory read data.
REQ-011 SHALL have ports: inbus  out  32  read data to CPU.
REQ-012 SHALL have ports: stall  out  1  CPU stall request.
REQ-013 SHALL have ports: dev_en  out  N_DEV  one-hot device select.
REQ-014 SHALL have ports: dev_wr  out  1  single-cycle device write pulse.
REQ-015 SHALL have ports: dev_din  out  32  write data broadcast to all devices.
REQ-016 SHALL have ports: dev_dout  in  32*N_DEV  device read data; slot k occupies bits [32k+31:32k].
REQ-017 SHALL have ports: dev_rdy  in  N_DEV  per-device ready.
REQ-018 SHALL have ports: err_clr  in  1  clears the error flag.
REQ-019 SHALL have ports: bus_err  out  1  sticky timeout flag.
REQ-020 SHALL have ports: err_adr  out  4  slot index of the last timed-out access.

Function
REQ-021 SHALL decode an I/O access as adr[23:6]==18'h3FFFF with (rd|wr); slot k = adr[5:2].
REQ-022 SHALL treat non-I/O cycles as pass-through: inbus=inbus0, stall=0, dev_en=0, dev_wr=0.
REQ-023 SHALL treat I/O accesses to a slot >= N_DEV as unmapped: inbus=0, stall=0, no state change.
REQ-024 SHALL implement the FSM states IDLE, ACC and DONE.
REQ-025 SHALL, in IDLE with a mapped I/O access, drive stall=1, clear cnt, latch k and the rd/wr type, and go to ACC on the next cycle.
REQ-026 SHALL, in ACC, drive stall=1 and dev_en[k]=1, and increment the 8-bit cnt each cycle, saturating at TIMEOUT.
REQ-027 SHALL complete an ACC cycle when cnt>=WAIT_CYC and dev_rdy[k]=1; in that cycle it SHALL pulse dev_wr=1 if the access is a write, capture rdata<=dev_dout[k] if it is a read, and go to DONE.
REQ-028 SHALL abort an ACC cycle when cnt==TIMEOUT and the completion condition is false; on abort it SHALL set rdata<=32'hFFFFFFFF, bus_err<=1 and err_adr<=k, issue no dev_wr, and go to DONE.
REQ-029 SHALL, in DONE, drive stall=0, inbus=rdata (32'h0 for writes) and dev_en=0, and return to IDLE unconditionally.
REQ-030 SHALL make the minimum access take 2 stall cycles plus the DONE cycle; a timeout takes TIMEOUT+2 stall cycles.
REQ-031 SHALL let an I/O access in IDLE immediately after DONE start a new transaction, supporting back-to-back accesses.
REQ-032 SHALL drive dev_din=outbus combinationally at all times.
REQ-033 SHALL clear bus_err when err_clr=1; if err_clr and a new timeout occur in the same cycle, the timeout SHALL win.
REQ-034 SHALL require the CPU to hold adr, rd, wr and outbus stable while stall=1; the block SHALL ignore changes to them in ACC.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, enter IDLE and clear cnt, rdata, bus_err and err_adr to 0, including mid-ACC; no dev_wr SHALL be issued in the reset cycle.
REQ-036 SHALL, while rst=1, drive stall=0, dev_en=0 and dev_wr=0.

Verification
REQ-037 SHALL cover: read of adr=24'hFFFFC4 (slot 1), WAIT_CYC=0, dev_rdy=1, dev_dout[63:32]=32'h12345678 -> stall high 2 cycles, then inbus=32'h12345678 with stall=0.
REQ-038 SHALL cover: write to slot 2 with dev_rdy[2] rising 5 cycles into ACC, outbus=32'hA5A5A5A5 -> exactly one dev_wr pulse while dev_en[2]=1 and dev_din=32'hA5A5A5A5, then DONE.
REQ-039 SHALL cover: read of slot 3 with dev_rdy[3]=0, TIMEOUT=8 -> 10 stall cycles, then inbus=32'hFFFFFFFF, bus_err=1, err_adr=3; err_clr then -> bus_err=0.
REQ-040 SHALL cover: read of adr=24'h000100 and read of an unmapped slot 9 with N_DEV=4 -> stall=0 throughout; inbus=inbus0 and 32'h0 respectively.
REQ-041 SHALL cover: rst asserted on the 3rd ACC cycle of a write -> IDLE next cycle, no dev_wr, stall=0, and registers cleared.
REQ-042 SHALL cover: WAIT_CYC=3 with dev_rdy held at 1 -> completion only when cnt=3, with 5 stall cycles total.
